// File: rtl/renkon_serial_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the renkon serial controller.
// Holds default widths, FIFO depth, read latency and the core-count clamp.
package renkon_serial_ctrl_pkg;

  localparam int DWIDTH         = 16;
  localparam int OUTSIZE        = 12;
  localparam int RENKON_CORELOG = 3;
  localparam int FIFO_DEPTH     = 4;
  localparam int RD_LAT         = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAPT  = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  function automatic int unsigned clamp_cores(
    input int unsigned n,
    input int unsigned lim
  );
    return (n > lim) ? lim : n;
  endfunction

endpackage

// File: rtl/renkon_serial_ctrl_fifo.sv
// renkon_serial_fifo: small synchronous FIFO with registered count.
// Ports: push/push_data in, pop in, pop_data/valid/count out.
module renkon_serial_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign pop_data = mem[rptr];
  assign valid    = (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= nxt(wptr);
      end
      if (do_pop) begin
        rptr <= nxt(rptr);
      end
      // simultaneous push and pop leaves count unchanged
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/renkon_serial_ctrl.sv
// Serial-matrix controller: broadcast capture, then per-core drain to a stream.
// Optional RENKON_SERIAL_STALL_EN adds stall_cnt (out backpressure cycles).
module renkon_serial_ctrl
  import renkon_serial_ctrl_pkg::*;
#(
  parameter int DWIDTH         = renkon_serial_ctrl_pkg::DWIDTH,
  parameter int OUTSIZE        = renkon_serial_ctrl_pkg::OUTSIZE,
  parameter int RENKON_CORELOG = renkon_serial_ctrl_pkg::RENKON_CORELOG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_start,
  input  logic [OUTSIZE-1:0]      wr_len,
  input  logic                    in_valid,
  input  logic                    rd_start,
  input  logic [OUTSIZE-1:0]      rd_len,
  input  logic [RENKON_CORELOG:0] rd_cores,
  output logic                    serial_we,
  output logic [OUTSIZE-1:0]      serial_addr,
  output logic [RENKON_CORELOG:0] serial_re,
  input  logic [DWIDTH-1:0]       mat_data,
  output logic [DWIDTH-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
`ifdef RENKON_SERIAL_STALL_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int          CW    = RENKON_CORELOG + 1;
  localparam int unsigned NCORE = 1 << RENKON_CORELOG;
  localparam int          FCW   = $clog2(FIFO_DEPTH + 1);
  localparam int          OW    = $clog2(FIFO_DEPTH + RD_LAT + 1);

  state_t             state;
  logic [OUTSIZE-1:0] wcnt;
  logic [OUTSIZE-1:0] wlen;
  logic [OUTSIZE-1:0] rcnt;
  logic [OUTSIZE-1:0] rlen;
  logic [CW-1:0]      k;
  logic [CW-1:0]      ncores;
  logic [RD_LAT-1:0]  infl;
  logic [RD_LAT-1:0]  infl_last;
  logic [FCW-1:0]     fifo_count;
  logic [DWIDTH:0]    fifo_q;
  logic               fifo_valid;
  logic [OW-1:0]      occ;
  logic               room;
  logic               issue;
  logic               issue_last;
  logic               addr_end;

  // occupancy counts words already buffered plus reads still in flight,
  // so an issued read always has a FIFO slot when its data returns
  always_comb begin
    occ = OW'(fifo_count);
    for (int i = 0; i < RD_LAT; i++) begin
      occ = occ + OW'(infl[i]);
    end
  end

  assign room       = (occ < OW'(FIFO_DEPTH));
  assign addr_end   = (rcnt == rlen - OUTSIZE'(1));
  assign issue      = (state == DRAIN) && room;
  assign issue_last = issue && addr_end && (k == ncores);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wcnt        <= '0;
      wlen        <= '0;
      rcnt        <= '0;
      rlen        <= '0;
      k           <= '0;
      ncores      <= '0;
      infl        <= '0;
      infl_last   <= '0;
      serial_we   <= 1'b0;
      serial_re   <= '0;
      serial_addr <= '0;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      serial_we   <= 1'b0;
      serial_re   <= '0;
      serial_addr <= '0;
      infl        <= {infl[RD_LAT-2:0], issue};
      infl_last   <= {infl_last[RD_LAT-2:0], issue_last};
      unique case (state)
        IDLE: begin
          if (wr_start) begin
            if (wr_len == '0) begin
              done <= 1'b1;
            end else begin
              wlen  <= wr_len;
              wcnt  <= '0;
              state <= CAPT;
            end
          end else if (rd_start) begin
            if ((rd_len == '0) || (rd_cores == '0)) begin
              done <= 1'b1;
            end else begin
              rlen   <= rd_len;
              ncores <= CW'(clamp_cores(32'(rd_cores), NCORE));
              k      <= CW'(1);
              rcnt   <= '0;
              state  <= DRAIN;
            end
          end
        end
        CAPT: begin
          if (in_valid) begin
            serial_we   <= 1'b1;
            serial_addr <= wcnt;
            wcnt        <= wcnt + OUTSIZE'(1);
            if (wcnt == wlen - OUTSIZE'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (room) begin
            serial_re   <= k;
            serial_addr <= rcnt;
            if (addr_end) begin
              rcnt <= '0;
              k    <= k + CW'(1);
              if (k == ncores) begin
                state <= FLUSH;
              end
            end else begin
              rcnt <= rcnt + OUTSIZE'(1);
            end
          end
        end
        FLUSH: begin
          if ((fifo_count == '0) && (infl == '0)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
      endcase
    end
  end

  renkon_serial_fifo #(
    .WIDTH (DWIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (infl[RD_LAT-1]),
    .push_data ({infl_last[RD_LAT-1], mat_data}),
    .pop       (out_ready),
    .pop_data  (fifo_q),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign out_data  = fifo_q[DWIDTH-1:0];
  assign out_valid = fifo_valid;
  assign out_last  = fifo_valid & fifo_q[DWIDTH];

`ifdef RENKON_SERIAL_STALL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && !wr_start && rd_start) begin
      stall_cnt <= '0;
    end else if (((state == DRAIN) || (state == FLUSH)) &&
                 out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_renkon_serial_ctrl.sv
// Self-checking bench for renkon_serial_ctrl with a 1-cycle registered
// memory model whose word is {core, addr}, and a scoreboard queue.
module tb_renkon_serial_ctrl;

  localparam int DW = 16;
  localparam int OS = 12;
  localparam int CL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_start;
  logic [OS-1:0] wr_len;
  logic          in_valid;
  logic          rd_start;
  logic [OS-1:0] rd_len;
  logic [CL:0]   rd_cores;
  logic          serial_we;
  logic [OS-1:0] serial_addr;
  logic [CL:0]   serial_re;
  logic [DW-1:0] mat_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef RENKON_SERIAL_STALL_EN
  logic [31:0]   stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] iss_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) mat_data <= {serial_re, serial_addr};

  renkon_serial_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .wr_start    (wr_start),
    .wr_len      (wr_len),
    .in_valid    (in_valid),
    .rd_start    (rd_start),
    .rd_len      (rd_len),
    .rd_cores    (rd_cores),
    .serial_we   (serial_we),
    .serial_addr (serial_addr),
    .serial_re   (serial_re),
    .mat_data    (mat_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
`ifdef RENKON_SERIAL_STALL_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_start = 0; wr_len = '0; in_valid = 0;
    rd_start = 0; rd_len = '0; rd_cores = '0; out_ready = 0;
    tick(); tick();
    checks++;
    if ({out_valid, out_last, done, busy, serial_we, serial_re,
         serial_addr, out_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b l=%b d=%b b=%b we=%b re=%h a=%h dat=%h exp all 0",
               out_valid, out_last, done, busy, serial_we, serial_re,
               serial_addr, out_data);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({busy, done, out_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle got b=%b d=%b v=%b exp 000", busy, done, out_valid);
    end
  endtask

  task automatic test_capture();
    wr_len = 3; wr_start = 1;
    tick();
    wr_start = 0; in_valid = 1;
    checks++;
    if (busy !== 1'b1 || serial_we !== 1'b0) begin
      failures++;
      $display("FAIL capt_enter got b=%b we=%b exp b=1 we=0", busy, serial_we);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (serial_we !== 1'b1 || serial_addr !== OS'(i) ||
          serial_re !== '0 || done !== (i == 2)) begin
        failures++;
        $display("FAIL capt_beat%0d got we=%b a=%0d re=%0d d=%b exp we=1 a=%0d re=0 d=%b",
                 i, serial_we, serial_addr, serial_re, done, i, (i == 2));
      end
    end
    in_valid = 0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || serial_we !== 1'b0) begin
      failures++;
      $display("FAIL capt_end got d=%b b=%b we=%b exp 0 0 0", done, busy, serial_we);
    end
    // gap in in_valid, plus a rd_start while busy that must be ignored
    wr_len = 2; wr_start = 1;
    tick();
    wr_start = 0; in_valid = 1;
    tick();
    in_valid = 0; rd_start = 1; rd_len = 2; rd_cores = 1;
    checks++;
    if (serial_we !== 1'b1 || serial_addr !== 0) begin
      failures++;
      $display("FAIL gap_beat0 got we=%b a=%0d exp we=1 a=0", serial_we, serial_addr);
    end
    tick();
    rd_start = 0; in_valid = 1;
    checks++;
    if (serial_we !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL gap_idle got we=%b b=%b d=%b exp 0 1 0", serial_we, busy, done);
    end
    tick();
    in_valid = 0;
    checks++;
    if (serial_we !== 1'b1 || serial_addr !== 1 || done !== 1'b1) begin
      failures++;
      $display("FAIL gap_beat1 got we=%b a=%0d d=%b exp 1 1 1", serial_we, serial_addr, done);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || serial_re !== '0) begin
      failures++;
      $display("FAIL busy_start_ignored got b=%b re=%0d exp 0 0", busy, serial_re);
    end
  endtask

  task automatic test_simul_start();
    int bad = 0;
    wr_start = 1; rd_start = 1; wr_len = 1; rd_len = 2; rd_cores = 1;
    tick();
    wr_start = 0; rd_start = 0; in_valid = 1;
    checks++;
    if (busy !== 1'b1 || serial_re !== '0) begin
      failures++;
      $display("FAIL simul_enter got b=%b re=%0d exp 1 0", busy, serial_re);
    end
    tick();
    in_valid = 0;
    checks++;
    if (serial_we !== 1'b1 || done !== 1'b1) begin
      failures++;
      $display("FAIL simul_capt got we=%b d=%b exp 1 1", serial_we, done);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (serial_re !== '0 || out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL simul_rd_dropped got bad_cycles=%0d exp 0", bad);
    end
  endtask

  task automatic test_zero();
    for (int v = 0; v < 3; v++) begin
      int bad = 0;
      wr_len = (v == 0) ? OS'(0) : OS'(5);
      rd_len = (v == 1) ? OS'(0) : OS'(3);
      rd_cores = (v == 2) ? 4'd0 : 4'd2;
      wr_start = (v == 0);
      rd_start = (v != 0);
      out_ready = 1;
      tick();
      wr_start = 0; rd_start = 0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL zero%0d_done got d=%b b=%b exp 1 0", v, done, busy);
      end
      for (int i = 0; i < 5; i++) begin
        tick();
        if (done !== 1'b0 || out_valid !== 1'b0 ||
            serial_re !== '0 || serial_we !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL zero%0d_quiet got bad_cycles=%0d exp 0", v, bad);
      end
    end
  endtask

  task automatic run_drain(input int cores, input int len,
                           input int hold, input int abort_at);
    int ncore = (cores > 8) ? 8 : cores;
    int issued = 0;
    int got = 0;
    int first_iss = -1;
    int first_val = -1;
    int max_out = 0;
    int hold_iss = -1;
    bit fin = 0;
    logic [DW-1:0] w;
    logic [DW-1:0] e;
    exp_q.delete(); iss_q.delete();
    for (int c = 1; c <= ncore; c++) begin
      for (int a = 0; a < len; a++) begin
        w = DW'((c << OS) | a);
        exp_q.push_back(w);
        iss_q.push_back(w);
      end
    end
    rd_start = 1; rd_len = OS'(len); rd_cores = 4'(cores);
    out_ready = (hold == 0);
    tick();
    rd_start = 0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL drain_busy got %b exp 1", busy);
    end
    for (int c = 0; c < 3000 && !fin; c++) begin
      tick();
      if (serial_re !== '0) begin
        checks++;
        if (iss_q.size() == 0) begin
          failures++;
          $display("FAIL drain_extra_issue got re=%0d a=%0d exp none",
                   serial_re, serial_addr);
        end else begin
          w = iss_q.pop_front();
          if ({serial_re, serial_addr} !== w || serial_we !== 1'b0) begin
            failures++;
            $display("FAIL drain_issue got re=%0d a=%0d we=%b exp re=%0d a=%0d we=0",
                     serial_re, serial_addr, serial_we, w[DW-1:OS], w[OS-1:0]);
          end
        end
        issued++;
        if (first_iss < 0) first_iss = c;
      end
      if (out_valid === 1'b1 && first_val < 0) first_val = c;
      if (issued - got > max_out) max_out = issued - got;
      if (c == hold - 1) hold_iss = issued;
      if (abort_at > 0 && got == abort_at) begin
        rst = 1;
        tick();
        checks++;
        if ({out_valid, out_last, done, busy, serial_we, serial_re,
             serial_addr, out_data} !== '0) begin
          failures++;
          $display("FAIL abort_outputs got v=%b d=%b b=%b re=%0d a=%0d dat=%h exp all 0",
                   out_valid, done, busy, serial_re, serial_addr, out_data);
        end
        rst = 0;
        w = '0;
        for (int i = 0; i < 6; i++) begin
          tick();
          if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) w++;
        end
        checks++;
        if (w !== '0) begin
          failures++;
          $display("FAIL abort_no_done got bad_cycles=%0d exp 0", w);
        end
        exp_q.delete(); iss_q.delete();
        return;
      end
      out_ready = (c >= hold);
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL drain_extra_word got %h exp none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e || out_last !== (exp_q.size() == 0)) begin
            failures++;
            $display("FAIL drain_word%0d got %h last=%b exp %h last=%b",
                     got, out_data, out_last, e, (exp_q.size() == 0));
          end
        end
        got++;
      end
      if (done === 1'b1) begin
        fin = 1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL drain_done_state got v=%b b=%b exp 0 0", out_valid, busy);
        end
      end
    end
    checks++;
    if (!fin || got != ncore * len || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_complete got fin=%0d words=%0d exp fin=1 words=%0d",
               fin, got, ncore * len);
    end
    checks++;
    if (max_out > 4) begin
      failures++;
      $display("FAIL drain_outstanding got %0d exp <=4", max_out);
    end
    if (hold > 0) begin
      checks++;
      if (hold_iss != 4) begin
        failures++;
        $display("FAIL bp_halt got issued=%0d exp 4", hold_iss);
      end
    end else begin
      checks++;
      if (first_val - first_iss != 2) begin
        failures++;
        $display("FAIL drain_latency got %0d exp 2", first_val - first_iss);
      end
    end
  endtask

  task automatic test_drain();
    run_drain(2, 3, 0, 0);
  endtask

  task automatic test_backpressure();
    run_drain(8, 4, 20, 0);
  endtask

  task automatic test_clamp();
    run_drain(12, 2, 0, 0);
  endtask

  task automatic test_mid_reset();
    run_drain(4, 4, 0, 5);
    run_drain(2, 3, 0, 0);
  endtask

  task automatic test_back_to_back();
    wr_len = 1; wr_start = 1;
    tick();
    wr_start = 0; in_valid = 1;
    tick();
    in_valid = 0;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_capt got d=%b exp 1", done);
    end
    run_drain(3, 1, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_capture();
    test_simul_start();
    test_zero();
    test_drain();
    test_backpressure();
    test_clamp();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/renkon_serial_ctrl.md
RENKON_SERIAL_CTRL -- requirements
Module: renkon_serial_ctrl

Interface
REQ-001 SHALL take parameters: DWIDTH, default 16, data word width; OUTSIZE, default 12, serial memory address width; RENKON_CORELOG, default 3, log2 of the core count (8 cores).
REQ-002 SHALL have one clock, clk; reset rst, synchronous and active-high.
REQ-003 Ports, as name, direction, width, meaning:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- wr_start, in, 1, start capture phase.
- wr_len, in, OUTSIZE, words per core to capture.
- in_valid, in, 1, parallel core beat valid.
- rd_start, in, 1, start drain phase.
- rd_len, in, OUTSIZE, words per core to drain.
- rd_cores, in, RENKON_CORELOG+1, number of cores to drain.
- serial_we, out, 1, memory write enable.
- serial_addr, out, OUTSIZE, memory address.
- serial_re, out, RENKON_CORELOG+1, core select (0 = broadcast write).
- mat_data, in, DWIDTH, serial-matrix read data.
- out_data, out, DWIDTH, stream data.
- out_valid, out, 1, stream valid.
- out_ready, in, 1, stream ready.
- out_last, out, 1, final word of drain.
- busy, out, 1, not IDLE.
- done, out, 1, one-cycle completion pulse.

Function
REQ-004 SHALL implement FSM states IDLE, CAPT, DRAIN, FLUSH.
REQ-005 IDLE SHALL go to CAPT on wr_start and to DRAIN on rd_start; if both are asserted, wr_start SHALL win and rd_start SHALL be dropped.
REQ-006 Starts SHALL be ignored while busy=1. Operands SHALL be latched on start.
REQ-007 CAPT: each cycle with in_valid=1 SHALL drive serial_we=1, serial_re=0 and serial_addr=write counter, then increment the counter. After wr_len beats the FSM SHALL return to IDLE with done=1 for one cycle.
REQ-008 CAPT: in_valid=0 SHALL give serial_we=0 and leave the counter unchanged.
REQ-009 DRAIN SHALL issue reads with serial_re=k (1..rd_cores) and serial_addr=0..rd_len-1, address fastest, then core. When the address wraps to 0, k SHALL increment.
REQ-010 mat_data for a read issued in cycle t SHALL be valid at t+2. In-flight reads SHALL be tracked by a 2-stage valid shift register.
REQ-011 Returned data SHALL enter a 4-entry FIFO that drives out_data/out_valid. A word transfers on out_valid & out_ready.
REQ-012 A read SHALL issue only if (FIFO count + in-flight) < 4, so no returned data is ever lost under backpressure.
REQ-013 After the final issue the FSM SHALL enter FLUSH. It SHALL go to IDLE with done=1 when FIFO and in-flight are both empty.
REQ-014 out_last SHALL be 1 with the final drained word only.
REQ-015 wr_len=0, rd_len=0 or rd_cores=0 SHALL complete immediately: done one cycle after start, no memory access, no output.
REQ-016 rd_cores>8 SHALL be clamped to 8.
REQ-017 Outside CAPT/DRAIN the block SHALL drive serial_we=0, serial_re=0 and serial_addr=0.
REQ-018 FIFO push and pop in the same cycle SHALL leave the count unchanged.

Reset
REQ-019 rst SHALL set: state=IDLE; all counters, FIFO and in-flight bits to 0; and all outputs to 0 (out_valid, out_last, done, busy, serial_we, serial_re, serial_addr, out_data).
REQ-020 rst mid-operation SHALL abort at the next edge. Data in the FIFO and in flight SHALL be discarded, and no done pulse SHALL be emitted.

Configuration
REQ-021 With RENKON_SERIAL_STALL_EN defined:
- add output stall_cnt, 32 bits.
- count cycles in DRAIN/FLUSH with out_valid=1 and out_ready=0.
- clear on rst and on rd_start acceptance; saturate at all-ones.
REQ-022 Without RENKON_SERIAL_STALL_EN, the port and the counter SHALL be absent.

Structure
REQ-023 The state encoding, FIFO depth (4) and read latency (2) SHALL be constants in the shared renkon package alongside DWIDTH, OUTSIZE and RENKON_CORELOG.
REQ-024 The FIFO SHALL be a sub-module, renkon_serial_fifo (parameterised width and depth, registered count).

Verification
REQ-025 Capture: wr_len=3, in_valid high for 3 cycles -> serial_we=1 with addr 0,1,2 and serial_re=0; done at cycle 4.
REQ-026 Drain, no backpressure: rd_cores=2, rd_len=3, out_ready=1 -> serial_re/addr sequence (1,0)(1,1)(1,2)(2,0)(2,1)(2,2); out_valid first at issue+2; 6 words; out_last on the 6th; then done.
REQ-027 Backpressure: rd_cores=8, rd_len=4, out_ready=0 for 20 cycles -> issue halts after 4 outstanding; no word lost or duplicated; 32 words delivered in order after release.
REQ-028 Zero length: rd_len=0 -> done after 1 cycle; out_valid never asserted.
REQ-029 Simultaneous starts: wr_start=rd_start=1 in IDLE -> CAPT entered; rd_start ignored.
REQ-030 Mid-drain reset: rst at word 5 of 16 -> all outputs 0 next cycle; no done pulse; a new rd_start completes normally.
